// File: rtl/infix_postfix_engine_if.sv
// Token stream interface for the infix-to-postfix engine.
// master drives infix tokens and output backpressure; slave is the engine.
interface infix_postfix_engine_if #(
    parameter int unsigned DATA_W = 8
);
    logic              IN_STB;
    logic [DATA_W-1:0] IN_DAT;
    logic              IN_LAST;
    logic              IN_ACK;
    logic              OUT_STB;
    logic [DATA_W-1:0] OUT_DAT;
    logic              OUT_ACK;
    logic              FINISHED_ACK;
    logic [1:0]        ERR;

    modport master (
        output IN_STB, IN_DAT, IN_LAST, OUT_ACK,
        input  IN_ACK, OUT_STB, OUT_DAT, FINISHED_ACK, ERR
    );

    modport slave (
        input  IN_STB, IN_DAT, IN_LAST, OUT_ACK,
        output IN_ACK, OUT_STB, OUT_DAT, FINISHED_ACK, ERR
    );
endinterface

// File: rtl/infix_postfix_engine.sv
// Shunting-yard infix-to-postfix converter with an operator stack of DEPTH
// entries and a single registered output beat.
module infix_postfix_engine #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input logic                CLK,
    input logic                RST,
    infix_postfix_engine_if.slave bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [DATA_W-1:0] TokLParen = DATA_W'(8'h28);
    localparam logic [DATA_W-1:0] TokRParen = DATA_W'(8'h29);
    localparam logic [DATA_W-1:0] TokMul    = DATA_W'(8'h2A);
    localparam logic [DATA_W-1:0] TokAdd    = DATA_W'(8'h2B);
    localparam logic [DATA_W-1:0] TokSub    = DATA_W'(8'h2D);
    localparam logic [DATA_W-1:0] TokDiv    = DATA_W'(8'h2F);

    typedef enum logic [2:0] {
        StAccept, StDrainPrec, StDrainParen, StFlush, StDone, StAbsorb
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] stack_q [DEPTH];
    logic [CW-1:0]     cnt_q;
    logic [DATA_W-1:0] pend_q, pend_d;
    logic              last_q, last_d;
    logic [1:0]        err_q, err_d;
    logic              out_stb_q;
    logic [DATA_W-1:0] out_dat_q;

    logic              want_push, push, pop, clear, emit, push_last;
    logic              in_ack, fin, out_free, full, empty, xfer;
    logic [DATA_W-1:0] push_val, emit_val, top;
    logic [CW-1:0]     top_ptr;

    // '(' and operands rank 0, so any arithmetic operator outranks a '(' on the stack.
    function automatic logic [1:0] prec_of(input logic [DATA_W-1:0] tok);
        if (tok == TokMul || tok == TokDiv) return 2'd2;
        if (tok == TokAdd || tok == TokSub) return 2'd1;
        return 2'd0;
    endfunction

    assign top_ptr  = cnt_q - CW'(1);
    assign top      = stack_q[top_ptr[IW-1:0]];
    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CW'(DEPTH));
    assign out_free = !out_stb_q || bus.OUT_ACK;
    assign xfer     = bus.IN_STB && in_ack;

    // Next-state, stack control and output-beat decisions.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        last_d    = last_q;
        err_d     = err_q;
        want_push = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        clear     = 1'b0;
        push_val  = pend_q;
        push_last = last_q;
        emit      = 1'b0;
        emit_val  = top;
        in_ack    = 1'b0;
        fin       = 1'b0;
        unique case (state_q)
            StAccept: begin
                in_ack = out_free;
                if (xfer) begin
                    if (bus.IN_DAT == TokLParen) begin
                        want_push = 1'b1;
                        push_val  = bus.IN_DAT;
                        push_last = bus.IN_LAST;
                        state_d   = bus.IN_LAST ? StFlush : StAccept;
                    end else if (bus.IN_DAT == TokRParen) begin
                        last_d  = bus.IN_LAST;
                        state_d = StDrainParen;
                    end else if (prec_of(bus.IN_DAT) != 2'd0) begin
                        pend_d = bus.IN_DAT;
                        last_d = bus.IN_LAST;
                        if (empty || prec_of(top) < prec_of(bus.IN_DAT)) begin
                            want_push = 1'b1;
                            push_val  = bus.IN_DAT;
                            push_last = bus.IN_LAST;
                            state_d   = bus.IN_LAST ? StFlush : StAccept;
                        end else begin
                            state_d = StDrainPrec;
                        end
                    end else begin
                        emit     = 1'b1;
                        emit_val = bus.IN_DAT;
                        state_d  = bus.IN_LAST ? StFlush : StAccept;
                    end
                end
            end
            StDrainPrec: begin
                if (empty || prec_of(top) < prec_of(pend_q)) begin
                    want_push = 1'b1;
                    state_d   = last_q ? StFlush : StAccept;
                end else if (out_free) begin
                    pop  = 1'b1;
                    emit = 1'b1;
                end
            end
            StDrainParen: begin
                if (empty) begin
                    clear   = 1'b1;
                    err_d   = 2'd2;
                    state_d = last_q ? StDone : StAbsorb;
                end else if (top == TokLParen) begin
                    pop     = 1'b1;
                    state_d = last_q ? StFlush : StAccept;
                end else if (out_free) begin
                    pop  = 1'b1;
                    emit = 1'b1;
                end
            end
            StFlush: begin
                if (empty) begin
                    state_d = StDone;
                end else if (top == TokLParen) begin
                    // The expression is already complete, so report straight away.
                    clear   = 1'b1;
                    err_d   = 2'd3;
                    state_d = StDone;
                end else if (out_free) begin
                    pop  = 1'b1;
                    emit = 1'b1;
                end
            end
            StDone: begin
                if (!out_stb_q) begin
                    fin     = 1'b1;
                    err_d   = 2'd0;
                    last_d  = 1'b0;
                    state_d = StAccept;
                end
            end
            StAbsorb: begin
                in_ack = 1'b1;
                if (bus.IN_STB && bus.IN_LAST) state_d = StDone;
            end
            default: state_d = StAccept;
        endcase
        // A push into a full stack is dropped and aborts the expression.
        if (want_push) begin
            if (full) begin
                clear   = 1'b1;
                err_d   = 2'd1;
                state_d = push_last ? StDone : StAbsorb;
            end else begin
                push = 1'b1;
            end
        end
    end

    // Control state, stack pointer and output register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StAccept;
            cnt_q     <= '0;
            pend_q    <= '0;
            last_q    <= 1'b0;
            err_q     <= 2'd0;
            out_stb_q <= 1'b0;
            out_dat_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            last_q  <= last_d;
            err_q   <= err_d;
            if (clear)     cnt_q <= '0;
            else if (push) cnt_q <= cnt_q + CW'(1);
            else if (pop)  cnt_q <= cnt_q - CW'(1);
            if (emit) begin
                out_stb_q <= 1'b1;
                out_dat_q <= emit_val;
            end else if (bus.OUT_ACK) begin
                out_stb_q <= 1'b0;
            end
        end
    end

    // Stack storage; contents beyond cnt_q are don't-care so no reset is needed.
    always_ff @(posedge CLK) begin
        if (push) stack_q[cnt_q[IW-1:0]] <= push_val;
    end

    assign bus.IN_ACK       = in_ack && !RST;
    assign bus.FINISHED_ACK = fin && !RST;
    assign bus.OUT_STB      = out_stb_q;
    assign bus.OUT_DAT      = out_dat_q;
    assign bus.ERR          = err_q;
endmodule

// File: tb/tb_infix_postfix_engine.sv
// Bench for infix_postfix_engine: directed expressions plus random token
// streams, scored against a queue-based shunting-yard reference.
module tb_infix_postfix_engine;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 2;
    localparam logic [7:0] LP  = 8'h28;
    localparam logic [7:0] RP  = 8'h29;
    localparam logic [7:0] MUL = 8'h2A;
    localparam logic [7:0] ADD = 8'h2B;
    localparam logic [7:0] SUB = 8'h2D;
    localparam logic [7:0] DIV = 8'h2F;

    typedef struct packed {
        logic       fin;
        logic [7:0] dat;
        logic [1:0] err;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    infix_postfix_engine_if #(.DATA_W(DATA_W)) bus ();

    infix_postfix_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    bit         ack_rand = 1'b0;
    bit         gaps = 1'b0;
    bit         in_reset = 1'b1;
    logic [7:0] tq[$];
    logic [7:0] eq[$];
    logic [1:0] eerr;

    function automatic int prec(input logic [7:0] t);
        if (t == MUL || t == DIV) return 2;
        if (t == ADD || t == SUB) return 1;
        return 0;
    endfunction

    // Reference conversion of tq into eq/eerr; stops at the first error.
    task automatic run_model();
        logic [7:0] st[$];
        logic [7:0] x;
        bit         stop;
        bit         found;
        stop = 1'b0;
        eq.delete();
        eerr = 2'd0;
        foreach (tq[i]) begin
            if (!stop) begin
                if (tq[i] == LP) begin
                    if (st.size() == int'(DEPTH)) begin eerr = 2'd1; stop = 1'b1; end
                    else st.push_back(tq[i]);
                end else if (tq[i] == RP) begin
                    found = 1'b0;
                    while (!found && !stop) begin
                        if (st.size() == 0) begin
                            eerr = 2'd2;
                            stop = 1'b1;
                        end else begin
                            x = st.pop_back();
                            if (x == LP) found = 1'b1;
                            else eq.push_back(x);
                        end
                    end
                end else if (prec(tq[i]) > 0) begin
                    while (st.size() > 0 && prec(st[st.size()-1]) >= prec(tq[i]))
                        eq.push_back(st.pop_back());
                    if (st.size() == int'(DEPTH)) begin eerr = 2'd1; stop = 1'b1; end
                    else st.push_back(tq[i]);
                end else begin
                    eq.push_back(tq[i]);
                end
            end
        end
        while (!stop && st.size() > 0) begin
            x = st.pop_back();
            if (x == LP) begin eerr = 2'd3; stop = 1'b1; end
            else eq.push_back(x);
        end
    endtask

    task automatic push_expected(input bit with_fin);
        exp_t e;
        foreach (eq[i]) begin
            e = '{fin: 1'b0, dat: eq[i], err: 2'd0};
            sb.push_back(e);
        end
        if (with_fin) begin
            e = '{fin: 1'b1, dat: 8'd0, err: eerr};
            sb.push_back(e);
        end
    endtask

    task automatic send_tokens(input bit with_last);
        for (int i = 0; i < tq.size(); i++) begin
            int guard;
            bit done;
            guard = 0;
            done  = 1'b0;
            while (!done) begin
                @(negedge CLK);
                if (gaps && $urandom_range(0, 3) == 0) begin
                    bus.IN_STB = 1'b0;
                end else begin
                    bus.IN_STB  = 1'b1;
                    bus.IN_DAT  = tq[i];
                    bus.IN_LAST = with_last && (i == tq.size() - 1);
                    #1;
                    done = bus.IN_ACK;
                end
                guard++;
                if (!done && guard > 500) begin
                    checks++;
                    errors++;
                    $display("FAIL in_ack_timeout: token %0d not accepted, required accept", i);
                    done = 1'b1;
                end
            end
        end
        @(negedge CLK);
        bus.IN_STB  = 1'b0;
        bus.IN_LAST = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        repeat (3) @(negedge CLK);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected items pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, want);
        end
    endtask

    task automatic run_expr(input bit with_fin);
        push_expected(with_fin);
        send_tokens(with_fin);
    endtask

    // Monitor: drives OUT_ACK, scores every output beat and FINISHED_ACK pulse.
    initial begin
        exp_t       e;
        bit         hold;
        logic [7:0] hold_dat;
        hold = 1'b0;
        hold_dat = 8'd0;
        bus.OUT_ACK = 1'b0;
        forever begin
            @(negedge CLK);
            bus.OUT_ACK = ack_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (in_reset) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    checks++;
                    if (!(bus.OUT_STB && bus.OUT_DAT == hold_dat)) begin
                        errors++;
                        $display("FAIL hold: OUT_STB=%0b OUT_DAT=%0h required 1/%0h",
                                 bus.OUT_STB, bus.OUT_DAT, hold_dat);
                    end
                end
                if (bus.OUT_STB && bus.OUT_ACK) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL out_beat: got %0h, required no beat", bus.OUT_DAT);
                    end else begin
                        e = sb.pop_front();
                        if (e.fin || e.dat != bus.OUT_DAT) begin
                            errors++;
                            $display("FAIL out_beat: got %0h required %0h (finish=%0b)",
                                     bus.OUT_DAT, e.dat, e.fin);
                        end
                    end
                end
                hold     = bus.OUT_STB && !bus.OUT_ACK;
                hold_dat = bus.OUT_DAT;
                if (bus.FINISHED_ACK) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL finish: got pulse err=%0d, required none", bus.ERR);
                    end else begin
                        e = sb.pop_front();
                        if (!e.fin || e.err != bus.ERR) begin
                            errors++;
                            $display("FAIL finish: got err=%0d required err=%0d (beat %0h=%0b)",
                                     bus.ERR, e.err, e.dat, !e.fin);
                        end
                    end
                end
            end
        end
    end

    // Stimulus.
    initial begin
        int len;
        int r;
        bus.IN_STB  = 1'b0;
        bus.IN_DAT  = 8'd0;
        bus.IN_LAST = 1'b0;
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        #1;
        chk("in_ack_during_reset", 8'(bus.IN_ACK), 8'd0);
        chk("out_stb_reset", 8'(bus.OUT_STB), 8'd0);
        chk("out_dat_reset", bus.OUT_DAT, 8'd0);
        chk("finished_reset", 8'(bus.FINISHED_ACK), 8'd0);
        chk("err_reset", 8'(bus.ERR), 8'd0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("in_ack_after_reset", 8'(bus.IN_ACK), 8'd1);
        in_reset = 1'b0;

        tq = '{8'd3, ADD, 8'd4, MUL, 8'd2};
        eq = '{8'd3, 8'd4, 8'd2, MUL, ADD}; eerr = 2'd0;
        run_expr(1'b1); wait_idle();

        tq = '{LP, 8'd1, ADD, 8'd2, RP, MUL, 8'd3};
        eq = '{8'd1, 8'd2, ADD, 8'd3, MUL}; eerr = 2'd0;
        run_expr(1'b1); wait_idle();

        tq = '{8'd8, SUB, 8'd3, SUB, 8'd2};
        eq = '{8'd8, 8'd3, SUB, 8'd2, SUB}; eerr = 2'd0;
        run_expr(1'b1); wait_idle();

        tq = '{LP, LP, LP, 8'd1};
        eq.delete(); eerr = 2'd1;
        run_expr(1'b1); wait_idle();

        tq = '{8'd1, RP, 8'd2};
        eq = '{8'd1}; eerr = 2'd2;
        run_expr(1'b1); wait_idle();

        tq = '{LP, 8'd1};
        eq = '{8'd1}; eerr = 2'd3;
        run_expr(1'b1); wait_idle();

        // Backpressure and input gaps on the first expression.
        ack_rand = 1'b1;
        gaps = 1'b1;
        repeat (3) begin
            tq = '{8'd3, ADD, 8'd4, MUL, 8'd2};
            eq = '{8'd3, 8'd4, 8'd2, MUL, ADD}; eerr = 2'd0;
            run_expr(1'b1);
        end
        wait_idle();

        // Reset mid-expression: the operand already emitted is the only beat.
        ack_rand = 1'b0;
        gaps = 1'b0;
        tq = '{8'd3, ADD};
        eq = '{8'd3};
        run_expr(1'b0); wait_idle();
        in_reset = 1'b1;
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("in_ack_mid_reset", 8'(bus.IN_ACK), 8'd0);
        @(negedge CLK);
        RST = 1'b0;
        sb.delete();
        #1;
        chk("in_ack_post_mid_reset", 8'(bus.IN_ACK), 8'd1);
        chk("out_stb_post_mid_reset", 8'(bus.OUT_STB), 8'd0);
        chk("err_post_mid_reset", 8'(bus.ERR), 8'd0);
        in_reset = 1'b0;
        tq = '{8'd5, MUL, 8'd6};
        eq = '{8'd5, 8'd6, MUL}; eerr = 2'd0;
        run_expr(1'b1); wait_idle();

        // Random token streams, scored against the reference model.
        ack_rand = 1'b1;
        gaps = 1'b1;
        repeat (80) begin
            tq.delete();
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) begin
                r = $urandom_range(0, 99);
                if (r < 50)      tq.push_back(8'($urandom_range(0, 39)));
                else if (r < 62) tq.push_back(ADD);
                else if (r < 70) tq.push_back(SUB);
                else if (r < 78) tq.push_back(MUL);
                else if (r < 82) tq.push_back(DIV);
                else if (r < 92) tq.push_back(LP);
                else             tq.push_back(RP);
            end
            run_model();
            run_expr(1'b1);
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
